ipv4_tx_framer: RTL and testbench
=================================

Name: ipv4_tx_framer

Overview:
Downstream neighbour of the TCP segment builder. Accepts one complete TCP segment (header plus FIX payload) as a wide parallel word and prepends a 20-byte IPv4 header with a computed header checksum. It serializes header and segment as a byte stream with valid/ready flow control toward the MAC/Ethernet framer.

Parameters:
SEG_LEN, 282, TCP segment length in bytes (TCP header + payload); constraint 20 <= SEG_LEN <= 65515
SRCADDR, 32'h7f000001, IPv4 source address
DESADDR, 32'h7f000001, IPv4 destination address
TTL, 8'd64, time-to-live field
PROTOCOL, 8'd6, protocol field

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
seg_valid  input  1  segment word valid
seg_ready  output  1  framer can accept a segment
seg_data  input  SEG_LEN*8  segment; byte i = seg_data[8*i+7:8*i], emitted in ascending i
m_data  output  8  output byte
m_valid  output  1  m_data valid
m_ready  input  1  downstream accepts byte
m_last  output  1  high with final byte of the packet
busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (rst_n=0 at posedge clk): m_valid=0, m_last=0, m_data=0, seg_ready=1, busy=0, ident=0, FSM=IDLE. Reset mid-packet abandons the packet; no m_last is emitted.
- FSM states: IDLE -> CSUM -> HDR -> PAY -> IDLE.
- IDLE: seg_ready=1. On seg_valid & seg_ready, latch seg_data into the segment buffer and go to CSUM. seg_ready=0 in all other states.
- CSUM: 10 cycles, one 16-bit header word per cycle. Words in order: 16'h4500, total_len, ident, 16'h4000 (DF set, frag offset 0), {TTL,PROTOCOL}, 16'h0000, SRCADDR[31:16], SRCADDR[15:0], DESADDR[31:16], DESADDR[15:0].
- total_len = 20 + SEG_LEN, 16 bits.
- Accumulator is 17 bits; fold the carry back into bit 0 every cycle (end-around carry).
- Checksum = ~acc[15:0] after the 10th word.
- Latency: segment accepted in cycle T; first header byte presented with m_valid=1 in cycle T+11.
- HDR: emit 20 header bytes big-endian (most significant byte of each word first), with the checksum in bytes 10-11. The byte index advances only on m_valid & m_ready.
- PAY: emit segment bytes 0..SEG_LEN-1. m_last=1 with byte SEG_LEN-1. On the handshake of that byte, go to IDLE and increment ident (16-bit, wraps 16'hFFFF -> 0).
- Backpressure: while m_valid & ~m_ready, m_data/m_last hold stable. m_valid never drops until the handshake occurs.
- The byte counter is 16 bits; total bytes emitted per packet = 20 + SEG_LEN.
- A seg_valid pulse while busy is ignored (not latched). The upstream must hold seg_valid until seg_ready.
- seg_ready rises in the cycle after the last-byte handshake, so back-to-back packets have a 1-cycle IDLE gap.

Optional Feature:
Macro IPV4_TX_STATS_EN.
- Defined: adds output pkt_count [31:0] and output byte_count [31:0], both reset to 0.
  - pkt_count increments on each last-byte handshake.
  - byte_count increments on every m_valid & m_ready.
  - Both wrap at 2^32.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Decomposition:
- Package ipv4_pkg:
  - constants IPV4_VER_IHL=16'h4500, IPV4_FLAGS_DF=16'h4000, IPV4_HDR_LEN=20
  - FSM state enum {IDLE, CSUM, HDR, PAY}
  - function ones_add16 (17-bit add with fold)
- Sub-module ip_hdr_csum: sequential ones'-complement accumulator.
  - Inputs: clk, rst_n, clr, word_valid, word[15:0].
  - Output: csum[15:0] (inverted folded sum).
  - Shared later with the IPv4 receive checker.

Test Plan:
- Defaults, ident=0, m_ready=1, segment bytes i=i[7:0] -> bytes 0-11 = 45 00 01 2E 00 00 40 00 40 06 3B C8, bytes 12-19 = 7F 00 00 01 7F 00 00 01. Then 00 01 02 ... ; m_last on byte 301 (value 8'h19); first m_valid at T+11.
- Second packet back-to-back -> ident bytes 00 01, checksum 3B C7; seg_ready low from acceptance until the cycle after m_last handshake.
- Random m_ready (~50% duty) -> byte sequence identical to the m_ready=1 case; m_data stable whenever m_valid & ~m_ready.
- seg_valid asserted during PAY with different data -> ignored; the in-flight packet is unchanged and the new segment is accepted only once seg_ready=1.
- rst_n=0 at header byte 5 -> next cycle m_valid=0, seg_ready=1. The next packet carries ident 00 00 and checksum 3B C8.
- Force ident=16'hFFFF, send two packets -> second packet carries ident 00 00. With IPV4_TX_STATS_EN, pkt_count=2 and byte_count=604.

Source files
------------

// File: rtl/ipv4_tx_framer_pkg.sv
// Shared IPv4 constants, framer FSM states and the ones'-complement add
// helper used by the header checksum logic.
package ipv4_pkg;

  localparam logic [15:0] IPV4_VER_IHL  = 16'h4500;
  localparam logic [15:0] IPV4_FLAGS_DF = 16'h4000;
  localparam int          IPV4_HDR_LEN  = 20;

  typedef enum logic [1:0] {IDLE, CSUM, HDR, PAY} fsm_e;

  // 17-bit add with the carry folded straight back into bit 0, so the
  // returned value never has bit 16 set.
  function automatic logic [16:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {1'b0, s[15:0] + {15'd0, s[16]}};
  endfunction

endpackage

// File: rtl/ipv4_tx_framer_csum.sv
// ip_hdr_csum: sequential ones'-complement accumulator over 16-bit words.
// Also intended for reuse by the IPv4 receive checker.
module ip_hdr_csum
  import ipv4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        word_valid,
  input  logic [15:0] word,
  output logic [15:0] csum
);

  logic [16:0] r_acc;

  // Accumulate one word per valid cycle with end-around carry.
  always_ff @(posedge clk) begin
    if (!rst_n || clr)   r_acc <= '0;
    else if (word_valid) r_acc <= ones_add16(r_acc[15:0], word);
  end

  // Bit 16 is always folded already; adding it keeps the result correct
  // should the accumulator ever be loaded with an unfolded value.
  assign csum = ~(r_acc[15:0] + {15'd0, r_acc[16]});

endmodule

// File: rtl/ipv4_tx_framer.sv
// ipv4_tx_framer: latches one TCP segment, computes the IPv4 header
// checksum over 10 cycles, then streams the 20-byte header followed by the
// segment bytes with valid/ready flow control.
// Optional counters: define IPV4_TX_STATS_EN to add pkt_count/byte_count.
module ipv4_tx_framer
  import ipv4_pkg::*;
#(
  parameter int          SEG_LEN  = 282,
  parameter logic [31:0] SRCADDR  = 32'h7f000001,
  parameter logic [31:0] DESADDR  = 32'h7f000001,
  parameter logic [7:0]  TTL      = 8'd64,
  parameter logic [7:0]  PROTOCOL = 8'd6
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seg_valid,
  output logic                 seg_ready,
  input  logic [SEG_LEN*8-1:0] seg_data,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy
`ifdef IPV4_TX_STATS_EN
  ,
  output logic [31:0]          pkt_count,
  output logic [31:0]          byte_count
`endif
);

  localparam logic [15:0] TOTAL_LEN = 16'(IPV4_HDR_LEN + SEG_LEN);
  localparam logic [15:0] LAST_IDX  = 16'(SEG_LEN - 1);

  fsm_e                 r_state;
  logic [15:0]          r_cnt;
  logic [15:0]          r_ident;
  logic [SEG_LEN*8-1:0] r_seg;

  logic        w_hs, w_accept;
  logic [3:0]  w_widx;
  logic [15:0] w_word, w_csum;
  logic [7:0]  w_hbyte, w_pbyte;

  assign w_hs     = m_valid & m_ready;
  assign w_accept = seg_valid & seg_ready;

  // CSUM walks header words by counter; HDR walks bytes, two per word.
  assign w_widx = (r_state == HDR) ? r_cnt[4:1] : r_cnt[3:0];

  // Header word table; the checksum slot reads zero while summing.
  always_comb begin
    w_word = 16'h0000;
    case (w_widx)
      4'd0: w_word = IPV4_VER_IHL;
      4'd1: w_word = TOTAL_LEN;
      4'd2: w_word = r_ident;
      4'd3: w_word = IPV4_FLAGS_DF;
      4'd4: w_word = {TTL, PROTOCOL};
      4'd5: w_word = (r_state == HDR) ? w_csum : 16'h0000;
      4'd6: w_word = SRCADDR[31:16];
      4'd7: w_word = SRCADDR[15:0];
      4'd8: w_word = DESADDR[31:16];
      4'd9: w_word = DESADDR[15:0];
      default: w_word = 16'h0000;
    endcase
  end

  assign w_hbyte = r_cnt[0] ? w_word[7:0] : w_word[15:8];
  assign w_pbyte = r_seg[8*int'(r_cnt) +: 8];

  ip_hdr_csum u_csum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (w_accept),
    .word_valid (r_state == CSUM),
    .word       (w_word),
    .csum       (w_csum)
  );

  // Outputs decode from registered state/counter, so they hold while stalled.
  assign seg_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign m_valid   = (r_state == HDR) || (r_state == PAY);
  assign m_last    = (r_state == PAY) && (r_cnt == LAST_IDX);
  assign m_data    = (r_state == HDR) ? w_hbyte :
                     (r_state == PAY) ? w_pbyte : 8'h00;

  // Segment buffer captured on acceptance only.
  always_ff @(posedge clk) begin
    if (w_accept) r_seg <= seg_data;
  end

  // Main sequencer: accept, sum header, stream header, stream payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ident <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_state <= CSUM;
          r_cnt   <= '0;
        end
        CSUM: if (r_cnt == 16'd9) begin
          r_state <= HDR;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
        HDR: if (w_hs) begin
          if (r_cnt == 16'(IPV4_HDR_LEN - 1)) begin
            r_state <= PAY;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        PAY: if (w_hs) begin
          if (r_cnt == LAST_IDX) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ident <= r_ident + 16'd1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef IPV4_TX_STATS_EN
  // Free-running packet and byte counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count  <= '0;
      byte_count <= '0;
    end else begin
      if (w_hs)          byte_count <= byte_count + 32'd1;
      if (w_hs & m_last) pkt_count  <= pkt_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ipv4_tx_framer.sv
// Self-checking bench for ipv4_tx_framer: randomized segments and
// backpressure against a packet-level reference model.
module tb_ipv4_tx_framer;

  localparam int          SL   = 282;
  localparam logic [31:0] SRC  = 32'h7f000001;
  localparam logic [31:0] DST  = 32'h7f000001;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            seg_valid;
  logic            seg_ready;
  logic [SL*8-1:0] seg_data;
  logic [7:0]      m_data;
  logic            m_valid;
  logic            m_ready;
  logic            m_last;
  logic            busy;
`ifdef IPV4_TX_STATS_EN
  logic [31:0]     pkt_count, byte_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] model_ident;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  ipv4_tx_framer #(.SEG_LEN(SL)) dut (
    .clk(clk), .rst_n(rst_n), .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_data(seg_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy)
`ifdef IPV4_TX_STATS_EN
    , .pkt_count(pkt_count), .byte_count(byte_count)
`endif
  );

  // Reference packet: header fields summed as plain integers, folded at the end.
  task automatic build_exp(input logic [SL*8-1:0] seg, input logic [15:0] id);
    logic [15:0] hw[10];
    int unsigned sum;
    hw[0] = 16'h4500;      hw[1] = 16'(20 + SL); hw[2] = id;
    hw[3] = 16'h4000;      hw[4] = {8'd64, 8'd6}; hw[5] = 16'h0000;
    hw[6] = SRC[31:16];    hw[7] = SRC[15:0];
    hw[8] = DST[31:16];    hw[9] = DST[15:0];
    sum = 0;
    for (int i = 0; i < 10; i++) sum += hw[i];
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    hw[5] = ~sum[15:0];
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(hw[i][15:8]);
      exp_q.push_back(hw[i][7:0]);
    end
    for (int i = 0; i < SL; i++) exp_q.push_back(seg[8*i +: 8]);
  endtask

  task automatic make_seg(input bit counting, output logic [SL*8-1:0] s);
    for (int i = 0; i < SL; i++) s[8*i +: 8] = counting ? 8'(i) : 8'($urandom);
  endtask

  // Called at #1 after a posedge; returns #1 after the accepting edge.
  task automatic send_seg(input logic [SL*8-1:0] s, output bit tmo);
    int n;
    seg_data = s;
    seg_valid = 1'b1;
    n = 0;
    while (!seg_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    tmo = !seg_ready;
    @(posedge clk); #1;
    seg_valid = 1'b0;
  endtask

  // Collects one packet into got_q; returns #1 after the m_last handshake edge.
  task automatic collect(input bit rnd, output int unstable, output int nlast,
                         output int rdy_busy, output bit tmo);
    bit prev_stall, done;
    logic [7:0] pd;
    logic pl;
    got_q.delete();
    unstable = 0; nlast = 0; rdy_busy = 0; done = 0;
    prev_stall = 0; pd = 8'h00; pl = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) unstable++;
      if (m_valid && seg_ready) rdy_busy++;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        if (m_last) begin
          nlast++;
          done = (got_q.size() >= 20 + SL) || 1'b1;
        end
      end
      prev_stall = m_valid && !m_ready;
      pd = m_data; pl = m_last;
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    tmo = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; seg_valid = 1'b0; m_ready = 1'b1; seg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b exp 0", m_last); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h exp 00", m_data); end
    checks++; if (seg_ready !== 1'b1) begin errors++; $display("FAIL reset_seg_ready got %b exp 1", seg_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
`ifdef IPV4_TX_STATS_EN
    checks++; if (pkt_count !== 32'd0 || byte_count !== 32'd0) begin
      errors++; $display("FAIL reset_stats got %0d/%0d exp 0/0", pkt_count, byte_count);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_ident = 16'h0000;
  endtask

  task automatic test_basic();
    logic [SL*8-1:0] s;
    bit tmo, ctmo;
    int n, unst, nl, rb;
    make_seg(1'b1, s);
    build_exp(s, model_ident);
    send_seg(s, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL basic_accept timed out"); end
    checks++; if (busy !== 1'b1 || seg_ready !== 1'b0) begin
      errors++; $display("FAIL basic_busy got busy=%b ready=%b exp 1/0", busy, seg_ready);
    end
    n = 0;
    while (!m_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 10) begin errors++; $display("FAIL basic_latency got %0d exp 10 cycles after accept edge", n); end
    collect(1'b0, unst, nl, rb, ctmo);
    model_ident++;
    checks++; if (ctmo) begin errors++; $display("FAIL basic_collect timed out"); end
    checks++; if (nl !== 1) begin errors++; $display("FAIL basic_nlast got %0d exp 1", nl); end
    checks++; if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL basic_len got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if ({got_q[10], got_q[11]} !== 16'h3BC8) begin
        errors++; $display("FAIL basic_csum got %h%h exp 3bc8", got_q[10], got_q[11]);
      end
      checks++; if (got_q[301] !== 8'h19) begin errors++; $display("FAIL basic_lastbyte got %h exp 19", got_q[301]); end
    end
    checks++; if (seg_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b exp 1", seg_ready); end
  endtask

  task automatic test_back_to_back();
    logic [SL*8-1:0] s;
    bit tmo, ctmo;
    int unst, nl, rb;
    make_seg(1'b1, s);
    build_exp(s, model_ident);
    send_seg(s, tmo);
    checks++; if (seg_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low got %b exp 0", seg_ready); end
    collect(1'b0, unst, nl, rb, ctmo);
    model_ident++;
    checks++; if (tmo || ctmo) begin errors++; $display("FAIL b2b_timeout accept=%b collect=%b", tmo, ctmo); end
    checks++; if (rb !== 0) begin errors++; $display("FAIL b2b_ready_during_pkt got %0d cycles exp 0", rb); end
    checks++; if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL b2b_len got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if ({got_q[4], got_q[5], got_q[10], got_q[11]} !== 32'h00013BC7) begin
        errors++; $display("FAIL b2b_ident_csum got %h%h %h%h exp 0001 3bc7", got_q[4], got_q[5], got_q[10], got_q[11]);
      end
    end
    checks++; if (seg_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after got %b exp 1", seg_ready); end
  endtask

  task automatic test_backpressure();
    logic [SL*8-1:0] s;
    bit tmo, ctmo;
    int unst, nl, rb;
    for (int p = 0; p < 2; p++) begin
      make_seg(1'b0, s);
      build_exp(s, model_ident);
      send_seg(s, tmo);
      collect(1'b1, unst, nl, rb, ctmo);
      model_ident++;
      checks++; if (tmo || ctmo) begin errors++; $display("FAIL bp_timeout accept=%b collect=%b", tmo, ctmo); end
      checks++; if (unst !== 0) begin errors++; $display("FAIL bp_stable got %0d unstable stalls exp 0", unst); end
      checks++; if (nl !== 1) begin errors++; $display("FAIL bp_nlast got %0d exp 1", nl); end
      checks++; if (got_q.size() !== exp_q.size()) begin
        errors++; $display("FAIL bp_len got %0d exp %0d", got_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [SL*8-1:0] a, b;
    logic [7:0] exp_b[$];
    bit tmo, tmo2, ctmo;
    int unst, nl, rb;
    make_seg(1'b0, a);
    make_seg(1'b0, b);
    build_exp(b, model_ident + 16'd1);
    exp_b = exp_q;
    build_exp(a, model_ident);
    send_seg(a, tmo);
    fork
      collect(1'b1, unst, nl, rb, ctmo);
      begin
        repeat (60) @(posedge clk);
        #1;
        send_seg(b, tmo2);
      end
    join
    model_ident++;
    checks++; if (tmo || tmo2 || ctmo) begin errors++; $display("FAIL ign_timeout %b %b %b", tmo, tmo2, ctmo); end
    checks++; if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL ign_a_len got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ign_a_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    collect(1'b0, unst, nl, rb, ctmo);
    model_ident++;
    checks++; if (ctmo) begin errors++; $display("FAIL ign_b_collect timed out"); end
    checks++; if (got_q.size() !== exp_b.size()) begin
      errors++; $display("FAIL ign_b_len got %0d exp %0d", got_q.size(), exp_b.size());
    end else begin
      for (int i = 0; i < exp_b.size(); i++) begin
        checks++; if (got_q[i] !== exp_b[i]) begin errors++; $display("FAIL ign_b_byte[%0d] got %h exp %h", i, got_q[i], exp_b[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [SL*8-1:0] s;
    bit tmo, ctmo;
    int n, unst, nl, rb;
    make_seg(1'b1, s);
    send_seg(s, tmo);
    n = 0;
    while (!m_valid && n < 50) begin @(posedge clk); #1; n++; end
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_ident = 16'h0000;
    checks++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin
      errors++; $display("FAIL rstmid_valid got valid=%b last=%b exp 0/0", m_valid, m_last);
    end
    checks++; if (seg_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_ready got ready=%b busy=%b exp 1/0", seg_ready, busy);
    end
    build_exp(s, model_ident);
    send_seg(s, tmo);
    collect(1'b0, unst, nl, rb, ctmo);
    model_ident++;
    checks++; if (tmo || ctmo) begin errors++; $display("FAIL rstmid_timeout %b %b", tmo, ctmo); end
    checks++; if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rstmid_len got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if ({got_q[4], got_q[5], got_q[10], got_q[11]} !== 32'h00003BC8) begin
        errors++; $display("FAIL rstmid_ident_csum got %h%h %h%h exp 0000 3bc8", got_q[4], got_q[5], got_q[10], got_q[11]);
      end
    end
  endtask

  task automatic test_ident_wrap();
    logic [SL*8-1:0] s;
    bit tmo, ctmo;
    int unst, nl, rb;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    force dut.r_ident = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_ident;
    model_ident = 16'hFFFF;
    for (int p = 0; p < 2; p++) begin
      make_seg(1'b0, s);
      build_exp(s, model_ident);
      send_seg(s, tmo);
      collect(1'b1, unst, nl, rb, ctmo);
      model_ident++;
      checks++; if (tmo || ctmo) begin errors++; $display("FAIL wrap_timeout %b %b", tmo, ctmo); end
      checks++; if (got_q.size() !== exp_q.size()) begin
        errors++; $display("FAIL wrap_len got %0d exp %0d", got_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if ({got_q[4], got_q[5]} !== (p == 0 ? 16'hFFFF : 16'h0000)) begin
          errors++; $display("FAIL wrap_ident pkt%0d got %h%h", p, got_q[4], got_q[5]);
        end
      end
    end
`ifdef IPV4_TX_STATS_EN
    checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL stats_pkt got %0d exp 2", pkt_count); end
    checks++; if (byte_count !== 32'd604) begin errors++; $display("FAIL stats_byte got %0d exp 604", byte_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_ignore_busy();
    test_reset_mid();
    test_ident_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
